// File: rtl/mlp_seq.sv
// mlp_seq: address and control sequencer for a two-layer MLP inference.
// It walks the layer-1 and layer-2 weights and drives the accumulator, bias and ReLU controls.
module mlp_seq #(
    parameter int N_IN  = 784,
    parameter int N_HID = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] ctr1,
    output logic [31:0] ctr2,
    output logic [9:0]  x_addr,
    output logic [4:0]  h_addr,
    output logic        acc1_clr,
    output logic        acc2_clr,
    output logic        acc1_en,
    output logic        acc2_en,
    output logic        acc1_bias,
    output logic        acc2_bias,
    output logic        relu_latch
);

    typedef enum logic [2:0] {
        IDLE,
        L1_RUN,
        L1_DRAIN,
        L1_ACT,
        L2_RUN,
        L2_DRAIN,
        DONE
    } state_t;

    // The bias sits one past the last weight, so it is also the terminal count
    localparam logic [31:0] LAST1 = 32'(N_IN);
    localparam logic [31:0] LAST2 = 32'(N_HID);

    state_t state;
    state_t next;
    logic   issue1;
    logic   issue2;
    logic   clr_q;
    logic   en1_q;
    logic   en2_q;
    logic   bias1_q;
    logic   bias2_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        next       = state;
        busy       = 1'b1;
        done       = 1'b0;
        relu_latch = 1'b0;
        issue1     = 1'b0;
        issue2     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next = L1_RUN;
            end
            L1_RUN: begin
                issue1 = !stall;
                if (!stall && ctr1 == LAST1) next = L1_DRAIN;
            end
            L1_DRAIN: next = L1_ACT;
            L1_ACT: begin
                relu_latch = 1'b1;
                next       = L2_RUN;
            end
            L2_RUN: begin
                issue2 = !stall;
                if (!stall && ctr2 == LAST2) next = L2_DRAIN;
            end
            L2_DRAIN: next = DONE;
            DONE: begin
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Layer-1 address counter: advances on issue, parks at the bias address
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || state == L1_ACT) begin
            ctr1 <= '0;
        end else if (issue1 && ctr1 != LAST1) begin
            ctr1 <= ctr1 + 32'd1;
        end
    end

    // Layer-2 address counter: advances on issue, parks at the bias address
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || state == DONE) begin
            ctr2 <= '0;
        end else if (issue2 && ctr2 != LAST2) begin
            ctr2 <= ctr2 + 32'd1;
        end
    end

    // Enables trail the issue by one cycle to line up with the memory read
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_q   <= 1'b0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            bias1_q <= 1'b0;
            bias2_q <= 1'b0;
        end else begin
            clr_q   <= (state == IDLE) && start;
            en1_q   <= issue1;
            en2_q   <= issue2;
            bias1_q <= issue1 && (ctr1 == LAST1);
            bias2_q <= issue2 && (ctr2 == LAST2);
        end
    end

    assign acc1_clr  = clr_q;
    assign acc2_clr  = clr_q;
    assign acc1_en   = en1_q;
    assign acc2_en   = en2_q;
    assign acc1_bias = bias1_q;
    assign acc2_bias = bias2_q;
    assign x_addr    = ctr1[9:0];
    assign h_addr    = ctr2[4:0];

endmodule

// File: tb/tb_mlp_seq.sv
// tb_mlp_seq: drives a default-size and a tiny mlp_seq with shared stimulus
// and checks both against a timeline model of an inference run.
module tb_mlp_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stall = 1'b0;

    logic        busy_o[2];
    logic        done_o[2];
    logic [31:0] c1[2];
    logic [31:0] c2[2];
    logic [9:0]  xa[2];
    logic [4:0]  ha[2];
    logic        clr1[2];
    logic        clr2[2];
    logic        en1[2];
    logic        en2[2];
    logic        bi1[2];
    logic        bi2[2];
    logic        relu[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mlp_seq #(.N_IN(784), .N_HID(32)) u0 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .busy(busy_o[0]), .done(done_o[0]),
        .ctr1(c1[0]), .ctr2(c2[0]), .x_addr(xa[0]), .h_addr(ha[0]),
        .acc1_clr(clr1[0]), .acc2_clr(clr2[0]),
        .acc1_en(en1[0]), .acc2_en(en2[0]),
        .acc1_bias(bi1[0]), .acc2_bias(bi2[0]),
        .relu_latch(relu[0])
    );

    mlp_seq #(.N_IN(4), .N_HID(2)) u1 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .busy(busy_o[1]), .done(done_o[1]),
        .ctr1(c1[1]), .ctr2(c2[1]), .x_addr(xa[1]), .h_addr(ha[1]),
        .acc1_clr(clr1[1]), .acc2_clr(clr2[1]),
        .acc1_en(en1[1]), .acc2_en(en2[1]),
        .acc1_bias(bi1[1]), .acc2_bias(bi2[1]),
        .relu_latch(relu[1])
    );

    // Model: pos is the non-stalled cycle index inside a run (0 = idle)
    int nin[2]  = '{784, 4};
    int nhid[2] = '{32, 2};
    int pos[2]  = '{0, 0};
    bit clr_m[2] = '{0, 0};
    bit en1_m[2] = '{0, 0};
    bit en2_m[2] = '{0, 0};
    bit b1_m[2]  = '{0, 0};
    bit b2_m[2]  = '{0, 0};

    function automatic bit in_l1(int i);
        return pos[i] >= 1 && pos[i] <= nin[i] + 1;
    endfunction

    function automatic bit in_l2(int i);
        return pos[i] >= nin[i] + 4 && pos[i] <= nin[i] + nhid[i] + 4;
    endfunction

    // Advance the model timeline on each rising edge
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                pos[i]   <= 0;
                clr_m[i] <= 0;
                en1_m[i] <= 0;
                en2_m[i] <= 0;
                b1_m[i]  <= 0;
                b2_m[i]  <= 0;
            end else begin
                clr_m[i] <= (pos[i] == 0) && start;
                en1_m[i] <= in_l1(i) && !stall;
                en2_m[i] <= in_l2(i) && !stall;
                b1_m[i]  <= in_l1(i) && !stall && (pos[i] - 1 == nin[i]);
                b2_m[i]  <= in_l2(i) && !stall && (pos[i] - nin[i] - 4 == nhid[i]);
                if (pos[i] == 0) pos[i] <= start ? 1 : 0;
                else if ((in_l1(i) || in_l2(i)) && stall) pos[i] <= pos[i];
                else if (pos[i] == nin[i] + nhid[i] + 6) pos[i] <= 0;
                else pos[i] <= pos[i] + 1;
            end
        end
    end

    function automatic logic [87:0] exp_vec(int i);
        int p, a, b, t;
        logic [31:0] e1, e2;
        p = pos[i]; a = nin[i]; b = nhid[i]; t = a + b + 6;
        e1 = '0; e2 = '0;
        if (p >= 1 && p <= a + 1) e1 = 32'(p - 1);
        else if (p == a + 2 || p == a + 3) e1 = 32'(a);
        if (p >= a + 4 && p <= a + b + 4) e2 = 32'(p - a - 4);
        else if (p == t - 1 || p == t) e2 = 32'(b);
        return {p != 0, p == t, clr_m[i], clr_m[i], en1_m[i], en2_m[i],
                b1_m[i], b2_m[i], p == a + 3, e1, e2, e1[9:0], e2[4:0]};
    endfunction

    function automatic logic [87:0] act_vec(int i);
        return {busy_o[i], done_o[i], clr1[i], clr2[i], en1[i], en2[i],
                bi1[i], bi2[i], relu[i], c1[i], c2[i], xa[i], ha[i]};
    endfunction

    int n_en1 = 0;
    int n_b1  = 0;
    int n_en2 = 0;
    int n_b2  = 0;

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== exp_vec(i)) begin
                errors++;
                if (errors < 30)
                    $display("FAIL cycle_u%0d t=%0t got %h want %h",
                             i, $time, act_vec(i), exp_vec(i));
            end
        end
        if (en1[0] === 1'b1) n_en1++;
        if (bi1[0] === 1'b1) n_b1++;
        if (en2[0] === 1'b1) n_en2++;
        if (bi2[0] === 1'b1) n_b2++;
    end

    task automatic chk(input string name, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    // Pulse start, optionally stall at u0 ctr1==stall_at, report done cycles
    task automatic run_measure(input int stall_at, input int stall_len,
                               output int d0, output int d1);
        int cyc;
        int sc;
        cyc = 0; sc = 0; d0 = -1; d1 = -1;
        start = 1'b1;
        while (cyc < 3000 && d0 < 0) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done_o[0] && d0 < 0) d0 = cyc;
            if (done_o[1] && d1 < 0) d1 = cyc;
            #1;
            start = 1'b0;
            stall = 1'b0;
            if (c1[0] == 32'(stall_at) && busy_o[0] && sc < stall_len) begin
                stall = 1'b1;
                sc++;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int d0, d1, k, t_prev, t_now, period_ok;
        int e1s, b1s, e2s, b2s;

        repeat (3) @(negedge clk);
        chk("reset_busy", busy_o[0], 0);
        chk("reset_ctr1", c1[0], 0);
        #1 rst = 1'b0;
        idle_cycles(2);

        e1s = n_en1; b1s = n_b1; e2s = n_en2; b2s = n_b2;
        run_measure(-1, 0, d0, d1);
        chk("done_latency_default", d0, 822);
        chk("done_latency_small", d1, 12);
        chk("acc1_en_count", n_en1 - e1s, 785);
        chk("acc1_bias_count", n_b1 - b1s, 1);
        chk("acc2_en_count", n_en2 - e2s, 33);
        chk("acc2_bias_count", n_b2 - b2s, 1);
        idle_cycles(3);

        run_measure(100, 5, d0, d1);
        chk("done_latency_stall", d0, 827);
        idle_cycles(3);

        start = 1'b1;
        k = 0; t_prev = -1; period_ok = 0;
        for (int c = 1; c < 4000 && k < 3; c++) begin
            @(negedge clk);
            if (done_o[0]) begin
                if (t_prev >= 0) begin
                    chk("b2b_period", c - t_prev, 823);
                    period_ok++;
                end
                t_prev = c;
                k++;
            end
        end
        chk("b2b_done_seen", period_ok, 2);
        #1 start = 1'b0;
        k = 0;
        while (busy_o[0] && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_drain_idle", busy_o[0], 0);
        idle_cycles(2);

        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        k = 0;
        while (c2[0] != 32'd17 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_ctr2_17", c2[0], 17);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy_o[0], 0);
        chk("rst_mid_done", done_o[0], 0);
        chk("rst_mid_ctr2", c2[0], 0);
        #1 rst = 1'b0;
        idle_cycles(2);
        run_measure(-1, 0, d0, d1);
        chk("done_after_rst", d0, 822);
        idle_cycles(3);

        for (int c = 0; c < 4000; c++) begin
            start = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 599) == 0);
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        stall = 1'b0;
        rst   = 1'b0;
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
